// File: rtl/vector_distance_seq_pkg.sv
// Shared types and width helpers for the GAM vector distance engine.
//   VECTOR_LEN   : default number of elements per GAM vector
//   dist_state_t : top-level FSM states
//   dist_acc_w() : accumulator width that cannot overflow for a given element width / length
package vector_distance_seq_pkg;

    localparam int unsigned VECTOR_LEN = 4;

    typedef enum logic [1:0] {
        DS_ACCUM,
        DS_SQRT,
        DS_OUT
    } dist_state_t;

    // 2*data_w+1 bits hold one (a-b)^2; $clog2(vec_len) more bits hold the sum of vec_len of them.
    function automatic int unsigned dist_acc_w(input int unsigned data_w, input int unsigned vec_len);
        return 2 * data_w + 1 + $clog2(vec_len);
    endfunction

endpackage

// File: rtl/vector_distance_seq_isqrt.sv
// Restoring bit-serial integer square root, one result bit per cycle, MSB first.
// The radicand is captured on start; root is valid when done pulses, ROOT_W cycles later.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load radicand and begin (ignored handling of overlap: a new start restarts)
//   radicand   : IN_W-bit unsigned input
//   busy       : iteration in progress
//   done       : one-cycle pulse, root holds floor(sqrt(radicand))
//   root       : ROOT_W-bit result
module vector_distance_seq_isqrt #(
    parameter int unsigned IN_W   = 19,
    parameter int unsigned ROOT_W = (IN_W + 1) / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IN_W-1:0]   radicand,
    output logic              busy,
    output logic              done,
    output logic [ROOT_W-1:0] root
);

    localparam int unsigned PAD_W = 2 * ROOT_W;
    localparam int unsigned REM_W = ROOT_W + 2;
    localparam int unsigned CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    logic [PAD_W-1:0]  r_rad;
    logic [REM_W-1:0]  r_rem;
    logic [ROOT_W-1:0] r_root;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;

    logic [REM_W-1:0]  w_rem_sh;
    logic [REM_W-1:0]  w_trial;
    logic              w_ge;
    logic [REM_W-1:0]  w_rem_nx;

    // Bring down the next radicand bit pair and try subtracting 4*root+1.
    // The remainder before the final step is below 2^ROOT_W, so truncating the shift is lossless.
    assign w_rem_sh = REM_W'({r_rem, r_rad[PAD_W-1 -: 2]});
    assign w_trial  = {r_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);
    assign w_rem_nx = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;

    // Iteration register set; done is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rad  <= PAD_W'(radicand);
                r_rem  <= '0;
                r_root <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rad  <= r_rad << 2;
                r_rem  <= w_rem_nx;
                r_root <= {r_root[ROOT_W-2:0], w_ge};
                if (r_cnt == CNT_W'(ROOT_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign root = r_root;

endmodule

// File: rtl/vector_distance_seq.sv
// Streaming, handshaked squared-Euclidean distance engine for GAM vector compare.
// Accumulates sum((a-b)^2) over one vector, then optionally takes floor(sqrt) serially.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : element-pair handshake; in_a/in_b signed, in_last ends the vector
//   out_valid/out_ready : result handshake, outputs held stable until accepted
//   out_dist_sq       : sum of squared differences (ACC_W bits)
//   out_dist          : floor(sqrt(out_dist_sq)), 0 when SQRT_EN=0
//   out_err           : in_last and the element count disagreed on the terminating beat
module vector_distance_seq
    import vector_distance_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned VEC_LEN = VECTOR_LEN,
    parameter int unsigned SQRT_EN = 1,
    parameter int unsigned ACC_W   = dist_acc_w(DATA_W, VEC_LEN),
    parameter int unsigned ROOT_W  = (ACC_W + 1) / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_dist_sq,
    output logic [ROOT_W-1:0] out_dist,
    output logic              out_err
);

    localparam int unsigned CNT_W = $clog2(VEC_LEN);
    localparam int unsigned SQ_W  = 2 * DATA_W + 2;

    dist_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_dist_sq;
    logic [ROOT_W-1:0]  r_out_dist;
    logic               r_out_err;

    logic signed [DATA_W:0] w_diff;
    logic signed [SQ_W-1:0] w_diff_x;
    logic signed [SQ_W-1:0] w_sq_s;
    logic [ACC_W-1:0]       w_sq;
    logic [ACC_W-1:0]       w_acc_next;
    logic                   w_fire;
    logic                   w_at_end;
    logic                   w_term;
    logic                   w_err;
    logic                   w_sq_start;
    logic                   w_sq_busy;
    logic                   w_sq_done;
    logic [ROOT_W-1:0]      w_root;

    // One extra bit keeps a-b exact over the full signed range; the square is non-negative.
    assign w_diff     = $signed({in_a[DATA_W-1], in_a}) - $signed({in_b[DATA_W-1], in_b});
    assign w_diff_x   = SQ_W'(w_diff);
    assign w_sq_s     = w_diff_x * w_diff_x;
    assign w_sq       = ACC_W'($unsigned(w_sq_s));
    assign w_acc_next = r_acc + w_sq;

    // The vector ends at whichever of in_last / full length comes first.
    assign w_fire     = (r_state == DS_ACCUM) && in_valid && r_in_ready;
    assign w_at_end   = (r_cnt == CNT_W'(VEC_LEN - 1));
    assign w_term     = in_last | w_at_end;
    assign w_err      = in_last ^ w_at_end;
    assign w_sq_start = w_fire && w_term && (SQRT_EN != 0);

    vector_distance_seq_isqrt #(
        .IN_W   (ACC_W),
        .ROOT_W (ROOT_W)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (w_sq_start),
        .radicand (w_acc_next),
        .busy     (w_sq_busy),
        .done     (w_sq_done),
        .root     (w_root)
    );

    // Control FSM with element counter, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= DS_ACCUM;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_dist_sq <= '0;
            r_out_dist    <= '0;
            r_out_err     <= 1'b0;
        end else begin
            case (r_state)
                DS_ACCUM: begin
                    if (w_fire) begin
                        r_acc <= w_acc_next;
                        if (w_term) begin
                            // Sum and error are final here; they stay put until the handshake.
                            r_cnt         <= '0;
                            r_out_dist_sq <= w_acc_next;
                            r_out_err     <= w_err;
                            r_in_ready    <= 1'b0;
                            r_state       <= (SQRT_EN != 0) ? DS_SQRT : DS_OUT;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DS_SQRT: begin
                    if (w_sq_done && !w_sq_busy) begin
                        r_out_dist  <= w_root;
                        r_out_valid <= 1'b1;
                        r_state     <= DS_OUT;
                    end
                end
                DS_OUT: begin
                    if (!r_out_valid) begin
                        // Only reached without the root stage: present the result one cycle later.
                        r_out_dist  <= '0;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= DS_ACCUM;
                    end
                end
                default: begin
                    r_state    <= DS_ACCUM;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_dist_sq = r_out_dist_sq;
    assign out_dist    = r_out_dist;
    assign out_err     = r_out_err;

endmodule

// File: tb/tb_vector_distance_seq.sv
module tb_vector_distance_seq;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 19;
    localparam int unsigned ROOT_W = 10;
    localparam int          SQRT_LAT = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_dist_sq;
    logic [ROOT_W-1:0] out_dist;
    logic              out_err;

    logic              in_valid2 = 1'b0;
    logic              in_ready2;
    logic [DATA_W-1:0] in_a2 = '0;
    logic [DATA_W-1:0] in_b2 = '0;
    logic              in_last2 = 1'b0;
    logic              out_valid2;
    logic              out_ready2 = 1'b0;
    logic [ACC_W-1:0]  out_dist_sq2;
    logic [ROOT_W-1:0] out_dist2;
    logic              out_err2;

    always #5 clk = ~clk;

    vector_distance_seq u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dist_sq (out_dist_sq),
        .out_dist    (out_dist),
        .out_err     (out_err)
    );

    vector_distance_seq #(.SQRT_EN(0)) u_dut_nosqrt (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .in_a        (in_a2),
        .in_b        (in_b2),
        .in_last     (in_last2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_dist_sq (out_dist_sq2),
        .out_dist    (out_dist2),
        .out_err     (out_err2)
    );

    typedef struct {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        int              n_beats;
        bit              last_flag;
        int              exp_sq;
        int              exp_dist;
        bit              exp_err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input int n,
                                input bit lf, input int sq, input int d, input bit e);
        vec_t v;
        v.a = a;
        v.b = b;
        v.n_beats = n;
        v.last_flag = lf;
        v.exp_sq = sq;
        v.exp_dist = d;
        v.exp_err = e;
        return v;
    endfunction

    // Present each beat, waiting (bounded) for in_ready; returns #1 after the terminating edge.
    task automatic send_vec(input vec_t v);
        for (int k = 0; k < v.n_beats; k++) begin
            int w;
            in_valid = 1'b1;
            in_a     = v.a[k];
            in_b     = v.b[k];
            in_last  = v.last_flag && (k == v.n_beats - 1);
            w = 0;
            while (!in_ready && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_post_hs_valid_ready"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    vec_t tbl[8];
    vec_t v_hold;
    vec_t v_abort;
    vec_t v_after;

    initial begin
        int lat;
        int rises;

        tbl[0] = mk(32'h00000003, 32'h00000400, 4, 1'b1, 25,     5,   1'b0);
        tbl[1] = mk(32'h80808080, 32'h7F7F7F7F, 4, 1'b1, 260100, 510, 1'b0);
        tbl[2] = mk(32'h01010101, 32'h00000000, 2, 1'b1, 2,      1,   1'b1);
        tbl[3] = mk(32'h00000000, 32'h00000000, 4, 1'b1, 0,      0,   1'b0);
        tbl[4] = mk(32'h04030201, 32'h00000000, 4, 1'b0, 30,     5,   1'b1);
        tbl[5] = mk(32'h000000FB, 32'h00000000, 1, 1'b1, 25,     5,   1'b1);
        tbl[6] = mk(32'hCE329C64, 32'h32CE649C, 4, 1'b1, 100000, 316, 1'b0);
        tbl[7] = mk(32'h0005F60A, 32'h00000000, 4, 1'b1, 225,    15,  1'b0);
        v_hold  = mk(32'h07070707, 32'h00000000, 4, 1'b1, 196, 14, 1'b0);
        v_abort = mk(32'h00000003, 32'h00000400, 4, 1'b1, 25,  5,  1'b0);
        v_after = mk(32'h00000105, 32'h00000000, 4, 1'b1, 26,  5,  1'b0);

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", 64'({out_valid, out_err, out_dist_sq, out_dist}), 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Without the root stage: result one cycle after the terminating beat, dist forced to 0
        for (int k = 0; k < 4; k++) begin
            in_valid2 = 1'b1;
            in_a2     = 8'd2;
            in_b2     = 8'd0;
            in_last2  = (k == 3);
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
        in_last2  = 1'b0;
        chk("nosqrt_valid_at_t", 64'({out_valid2, in_ready2}), 64'b00);
        @(posedge clk); #1;
        chk("nosqrt_valid_at_t1", 64'(out_valid2), 64'd1);
        chk("nosqrt_dist_sq", 64'(out_dist_sq2), 64'd16);
        chk("nosqrt_dist_err", 64'({out_dist2, out_err2}), 64'd0);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        chk("nosqrt_post_hs", 64'({out_valid2, in_ready2}), 64'b01);

        // Table of vectors through the root stage
        for (int i = 0; i < 8; i++) begin
            send_vec(tbl[i]);
            chk($sformatf("v%0d_busy_in_ready", i), 64'(in_ready), 64'd0);
            wait_valid(lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(SQRT_LAT));
            chk($sformatf("v%0d_dist_sq", i), 64'(out_dist_sq), 64'(tbl[i].exp_sq));
            chk($sformatf("v%0d_dist", i), 64'(out_dist), 64'(tbl[i].exp_dist));
            chk($sformatf("v%0d_err", i), 64'(out_err), 64'(tbl[i].exp_err));
            handshake($sformatf("v%0d", i));
        end

        // Back-pressure: hold out_ready low 5 cycles while the source pushes a stray beat
        send_vec(v_hold);
        wait_valid(lat);
        chk("hold_latency", 64'(lat), 64'(SQRT_LAT));
        in_valid = 1'b1;
        in_a     = 8'd100;
        in_b     = 8'd0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_c%0d", c),
                64'({out_valid, in_ready, out_err, out_dist_sq, out_dist}),
                64'({1'b1, 1'b0, 1'b0, 19'd196, 10'd14}));
        end
        in_valid = 1'b0;
        handshake("hold");

        // Reset in the 4th cycle of the root stage aborts the vector
        send_vec(v_abort);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_reset_outputs", 64'({out_valid, out_dist_sq}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        rises = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        chk("abort_no_result", 64'(rises), 64'd0);

        send_vec(v_after);
        wait_valid(lat);
        chk("after_abort_latency", 64'(lat), 64'(SQRT_LAT));
        chk("after_abort_dist_sq", 64'(out_dist_sq), 64'd26);
        chk("after_abort_dist", 64'(out_dist), 64'd5);
        handshake("after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
